// File: rtl/serial_mag_comp.sv
// Iterative magnitude comparator: examines one DIGIT-bit slice per clock, MSB slice first.
// Registered agb/alb/aeb flags and slice count are held until the next completion.
module serial_mag_comp #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 2,
  parameter int unsigned EARLY_EXIT = 1,
  localparam int unsigned NDIG      = WIDTH / DIGIT,
  localparam int unsigned CW        = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IdxTop = IW'(NDIG - 1);
  localparam logic [CW-1:0] NdigC  = CW'(NDIG);

  localparam logic StIdle    = 1'b0;
  localparam logic StCompare = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  logic             agb_q, agb_d, alb_q, alb_d, aeb_q, aeb_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] sa, sb;
  logic             differ, slice_gt, res_dec, res_gt, finish;

  always_comb begin
    a_sh = a_q >> (DIGIT * idx_q);
    b_sh = b_q >> (DIGIT * idx_q);
    sa   = a_sh[DIGIT-1:0];
    sb   = b_sh[DIGIT-1:0];
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (sgn_q && (idx_q == IdxTop)) begin
      sa[DIGIT-1] = ~sa[DIGIT-1];
      sb[DIGIT-1] = ~sb[DIGIT-1];
    end
    differ   = (sa != sb);
    slice_gt = (sa > sb);
    res_dec  = decided_q | differ;
    res_gt   = decided_q ? gt_q : slice_gt;
    finish   = ((EARLY_EXIT != 0) && differ) || (idx_q == '0);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    agb_d     = agb_q;
    alb_d     = alb_q;
    aeb_d     = aeb_q;
    cycles_d  = cycles_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          sgn_d     = signed_mode;
          idx_d     = IdxTop;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          state_d   = StCompare;
        end
      end
      StCompare: begin
        if (finish) begin
          agb_d    = res_dec & res_gt;
          alb_d    = res_dec & ~res_gt;
          aeb_d    = ~res_dec;
          cycles_d = NdigC - CW'(idx_q);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          decided_d = res_dec;
          gt_d      = res_gt;
          idx_d     = idx_q - IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      agb_q     <= 1'b0;
      alb_q     <= 1'b0;
      aeb_q     <= 1'b0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      agb_q     <= agb_d;
      alb_q     <= alb_d;
      aeb_q     <= aeb_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q == StCompare);
  assign done   = done_q;
  assign agb    = agb_q;
  assign alb    = alb_q;
  assign aeb    = aeb_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: one early-exit and one full-length instance share stimulus,
// results are checked against an arithmetic reference model.
module tb_serial_mag_comp;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy1, done1, agb1, alb1, aeb1;
  logic       busy0, done0, agb0, alb0, aeb0;
  logic [2:0] cyc1, cyc0;
  logic [2:0] prev1 = '0;
  logic [2:0] prev0 = '0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .agb(agb1), .alb(alb1), .aeb(aeb1), .cycles(cyc1)
  );

  serial_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy0), .done(done0), .agb(agb0), .alb(alb0), .aeb(aeb0), .cycles(cyc0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering by integer value, k = position of first differing 2-bit slice.
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                output logic [2:0] flags, output int k);
    int  xi, yi;
    bit  found;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    flags = {xi > yi, xi < yi, xi == yi};
    k = N;
    found = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && (x[2*i +: 2] != y[2*i +: 2])) begin
        k = N - i;
        found = 1;
      end
    end
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input int inj);
    logic [2:0] ef;
    int k, bc1, bc0, dc1, dc0, dm1, dm0;
    model(ta, tb_v, ts, ef, k);
    bc1 = 0; bc0 = 0; dc1 = 0; dc0 = 0; dm1 = -1; dm0 = -1;
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = ts; start = 1'b1;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (m == 0) begin
        start = 1'b0;
        check("hold_ee", 32'({agb1, alb1, aeb1}), 32'(prev1));
        check("hold_full", 32'({agb0, alb0, aeb0}), 32'(prev0));
      end
      if (busy1) bc1++;
      if (busy0) bc0++;
      if (done1) begin dc1++; dm1 = m; end
      if (done0) begin dc0++; dm0 = m; end
      if (m == inj) begin
        a = tb_v; b = ta; start = 1'b1;
      end else if (m == inj + 1) begin
        start = 1'b0;
      end
    end
    check("flags_ee", 32'({agb1, alb1, aeb1}), 32'(ef));
    check("cycles_ee", 32'(cyc1), 32'(k));
    check("busylen_ee", 32'(bc1), 32'(k));
    check("donecnt_ee", 32'(dc1), 32'd1);
    check("doneat_ee", 32'(dm1), 32'(k));
    check("flags_full", 32'({agb0, alb0, aeb0}), 32'(ef));
    check("cycles_full", 32'(cyc0), 32'(N));
    check("busylen_full", 32'(bc0), 32'(N));
    check("donecnt_full", 32'(dc0), 32'd1);
    check("doneat_full", 32'(dm0), 32'(N));
    prev1 = ef;
    prev0 = ef;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ee"}, 32'({busy1, done1, agb1, alb1, aeb1, cyc1}), 32'd0);
    check({tag, "_full"}, 32'({busy0, done0, agb0, alb0, aeb0, cyc0}), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    run_op(8'hA5, 8'hA5, 1'b0, -1);
    run_op(8'h80, 8'h7F, 1'b0, -1);
    run_op(8'h80, 8'h7F, 1'b1, -1);
    run_op(8'hA4, 8'hA5, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b1, -1);
    run_op(8'h00, 8'hFF, 1'b1, -1);
    // Start while busy, with swapped operands, must not disturb the running compare.
    run_op(8'hA4, 8'hA5, 1'b0, 2);

    // Back-to-back: second start lands in the done cycle.
    @(negedge clk);
    a = 8'hA4; b = 8'hA5; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_done1_ee", 32'({done1, agb1, alb1, aeb1}), 32'b1010);
    check("b2b_done1_full", 32'({done0, agb0, alb0, aeb0}), 32'b1010);
    a = 8'h80; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'({busy1, busy0, done1}), 32'b110);
    @(negedge clk);
    check("b2b_done2_ee", 32'({done1, agb1, alb1, aeb1, cyc1}), 32'({4'b1100, 3'd1}));
    check("b2b_busy_full", 32'(busy0), 32'd1);
    repeat (3) @(negedge clk);
    check("b2b_done2_full", 32'({done0, agb0, alb0, aeb0, cyc0}), 32'({4'b1100, 3'd4}));
    prev1 = 3'b100;
    prev0 = 3'b100;

    // Reset in cycle 2 of a 4-slice compare.
    @(negedge clk);
    a = 8'hA4; b = 8'hA5; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("midreset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cleared("postreset");
    end
    prev1 = '0;
    prev0 = '0;
    run_op(8'h3C, 8'h3D, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rb = 8'($urandom);
        1: rb = ra;
        default: rb = ra ^ 8'(1 << $urandom_range(0, 7));
      endcase
      run_op(ra, rb, 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
